// File: rtl/main_bus_arbiter.sv
// rtl/main_bus_arbiter.sv - round-robin arbiter producing active-low MainBus assert enables
// Optional MAIN_BUS_TURNAROUND_EN inserts a one-cycle idle gap on owner change.
module main_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  output logic [NREQ-1:0]           a_main_n,
  output logic                      grant_valid,
  output logic [$clog2(NREQ)-1:0]   grant_idx,
  output logic [7:0]                busy_cnt
);

  localparam int IW = $clog2(NREQ);

`ifdef MAIN_BUS_TURNAROUND_EN
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_OWN} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] a_main_n_d;
  logic            grant_valid_d;
  logic [IW-1:0]   grant_idx_d;
  logic [7:0]      busy_cnt_d;
`ifdef MAIN_BUS_TURNAROUND_EN
  logic [IW-1:0]   turn_w_q, turn_w_d;
`endif

  // Search rr_ptr+1 .. rr_ptr+NREQ; the owner itself is tried last.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] base);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NREQ;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  logic [IW:0]     pick;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] owner_mask;
  logic            others;
  logic            keep;
  logic            do_grant;
  logic            do_idle;
  logic [IW-1:0]   g_idx;

  always_comb begin
    pick       = rr_pick(req, rr_ptr_q);
    win_found  = pick[IW];
    win_idx    = pick[IW-1:0];
    owner_mask = NREQ'(1) << grant_idx;
    others     = |(req & ~owner_mask);
    keep       = req[grant_idx] & lock[grant_idx] & (~others | (busy_cnt < 8'(MAX_HOLD)));
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    a_main_n_d    = a_main_n;
    grant_valid_d = grant_valid;
    grant_idx_d   = grant_idx;
    busy_cnt_d    = busy_cnt;
    do_grant      = 1'b0;
    do_idle       = 1'b0;
    g_idx         = win_idx;
`ifdef MAIN_BUS_TURNAROUND_EN
    turn_w_d      = turn_w_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) do_grant = 1'b1;
      end
      S_OWN: begin
        if (keep) begin
          busy_cnt_d = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
        end else if (!win_found) begin
          do_idle = 1'b1;
`ifdef MAIN_BUS_TURNAROUND_EN
        end else if (win_idx != grant_idx) begin
          do_idle  = 1'b1;
          state_d  = S_TURN;
          turn_w_d = win_idx;
`endif
        end else begin
          do_grant = 1'b1;
        end
      end
`ifdef MAIN_BUS_TURNAROUND_EN
      S_TURN: begin
        // The bus already floated for a cycle, so any re-arbitration here is granted directly.
        if (req[turn_w_q]) begin
          do_grant = 1'b1;
          g_idx    = turn_w_q;
        end else if (win_found) begin
          do_grant = 1'b1;
        end else begin
          do_idle  = 1'b1;
        end
      end
`endif
      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d       = S_OWN;
      a_main_n_d    = ~(NREQ'(1) << g_idx);
      grant_valid_d = 1'b1;
      grant_idx_d   = g_idx;
      busy_cnt_d    = 8'd1;
      rr_ptr_d      = g_idx;
    end else if (do_idle) begin
      if (state_d == S_OWN) state_d = S_IDLE;
      a_main_n_d    = '1;
      grant_valid_d = 1'b0;
      grant_idx_d   = '0;
      busy_cnt_d    = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IW'(NREQ - 1);
      a_main_n    <= '1;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy_cnt    <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_main_n    <= a_main_n_d;
      grant_valid <= grant_valid_d;
      grant_idx   <= grant_idx_d;
      busy_cnt    <= busy_cnt_d;
    end
  end

`ifdef MAIN_BUS_TURNAROUND_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) turn_w_q <= '0;
    else          turn_w_q <= turn_w_d;
  end
`endif

endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb/tb_main_bus_arbiter.sv - self-checking bench for main_bus_arbiter
module tb_main_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
`ifdef MAIN_BUS_TURNAROUND_EN
  localparam bit TURN = 1'b1;
`else
  localparam bit TURN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] a_main_n;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [7:0] busy_cnt;

  int checks   = 0;
  int failures = 0;

  int m_owner, m_cnt, m_ptr, m_turn;

  always #5 clk = ~clk;

  main_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .lock(lock),
    .a_main_n(a_main_n), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .busy_cnt(busy_cnt)
  );

  function automatic int next_winner(logic [3:0] r, int base);
    for (int k = 1; k <= NREQ; k++)
      if (r[(base + k) % NREQ]) return (base + k) % NREQ;
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = NREQ - 1; m_turn = -1;
  endfunction

  function automatic void model_grant(int w);
    m_owner = w; m_cnt = 1; m_ptr = w; m_turn = -1;
  endfunction

  function automatic void model_step(logic [3:0] r, logic [3:0] l);
    int  w;
    bool_keep: begin end
    if (m_turn >= 0) begin
      if (r[m_turn]) model_grant(m_turn);
      else begin
        w = next_winner(r, m_ptr);
        if (w >= 0) model_grant(w);
        else begin m_owner = -1; m_cnt = 0; m_turn = -1; end
      end
    end else if (m_owner < 0) begin
      w = next_winner(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else if (r[m_owner] && l[m_owner] &&
                 (((r & ~(4'b1 << m_owner)) == 4'b0) || m_cnt < MAX_HOLD)) begin
      if (m_cnt < 255) m_cnt++;
    end else begin
      w = next_winner(r, m_owner);
      if (w < 0) begin m_owner = -1; m_cnt = 0; end
      else if (w == m_owner || !TURN) model_grant(w);
      else begin m_owner = -1; m_cnt = 0; m_turn = w; end
    end
  endfunction

  function automatic logic [3:0] exp_amn();
    return (m_owner >= 0) ? ~(4'b1 << m_owner) : 4'hF;
  endfunction

  task automatic tick(input logic [3:0] r, input logic [3:0] l);
    req = r; lock = l;
    model_step(r, l);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; lock = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'hF; lock = 4'hF;
    repeat (2) @(posedge clk); #1;
    checks++; if (a_main_n !== 4'hF) begin failures++; $display("FAIL reset_amn got=%b exp=1111", a_main_n); end
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_gv got=%b exp=0", grant_valid); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    checks++; if (busy_cnt !== 8'd0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy_cnt); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick(4'b0100, 4'b0000);
      checks++; if (a_main_n !== 4'b1011) begin failures++; $display("FAIL single_amn c=%0d got=%b exp=1011", c, a_main_n); end
      checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL single_idx c=%0d got=%0d exp=2", c, grant_idx); end
      checks++; if (busy_cnt !== 8'd1) begin failures++; $display("FAIL single_busy c=%0d got=%0d exp=1", c, busy_cnt); end
    end
    tick(4'b0000, 4'b0000);
    checks++; if (a_main_n !== 4'hF || grant_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b/%b exp=1111/0", a_main_n, grant_valid); end
  endtask

  task automatic test_rotate();
    int ei; bit ev;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick(4'hF, 4'h0);
      ev = TURN ? (c % 2 == 0) : 1'b1;
      ei = TURN ? ((c / 2) % 4) : (c % 4);
      if (!ev) ei = 0;
      checks++; if (grant_valid !== ev || grant_idx !== 2'(ei)) begin
        failures++; $display("FAIL rotate c=%0d got=%b/%0d exp=%b/%0d", c, grant_valid, grant_idx, ev, ei);
      end
    end
  endtask

  task automatic test_lock_hold();
    int ei, eb; bit ev;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(4'b0011, 4'b0001);
      if (c < MAX_HOLD) begin ev = 1; ei = 0; eb = c + 1; end
      else if (TURN) begin
        if (c == MAX_HOLD) begin ev = 0; ei = 0; eb = 0; end
        else begin ev = 1; ei = 1; eb = 1; end
      end else begin
        ev = 1; ei = (c == MAX_HOLD) ? 1 : 0; eb = 1;
      end
      checks++; if (grant_valid !== ev || grant_idx !== 2'(ei) || busy_cnt !== 8'(eb)) begin
        failures++; $display("FAIL lock_hold c=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", c, grant_valid, grant_idx, busy_cnt, ev, ei, eb);
      end
    end
  endtask

  task automatic test_saturate();
    int eb;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      tick(4'b0001, 4'b0001);
      eb = (c + 1 > 255) ? 255 : c + 1;
      checks++; if (a_main_n !== 4'b1110 || busy_cnt !== 8'(eb)) begin
        failures++; $display("FAIL saturate c=%0d got=%b/%0d exp=1110/%0d", c, a_main_n, busy_cnt, eb);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(4'b1000, 4'b1000);
    tick(4'b1000, 4'b1000);
    checks++; if (a_main_n !== 4'b0111) begin failures++; $display("FAIL areset_pre got=%b exp=0111", a_main_n); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (a_main_n !== 4'hF || grant_valid !== 1'b0 || busy_cnt !== 8'd0) begin
      failures++; $display("FAIL areset_async got=%b/%b/%0d exp=1111/0/0", a_main_n, grant_valid, busy_cnt);
    end
    req = 4'b0000; lock = 4'b0000;
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    tick(4'b1000, 4'b0000);
    checks++; if (a_main_n !== 4'b0111 || grant_idx !== 2'd3 || busy_cnt !== 8'd1) begin
      failures++; $display("FAIL areset_regrant got=%b/%0d/%0d exp=0111/3/1", a_main_n, grant_idx, busy_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] r, l;
    int wait_cnt [4];
    int max_wait, bound;
    bound = NREQ * (MAX_HOLD + (TURN ? 2 : 1));
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    do_reset();
    r = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
      l = 4'($urandom) | 4'($urandom);
      tick(r, l);
      for (int i = 0; i < 4; i++) begin
        if (r[i] && m_owner != i) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      checks++; if ($countones(~a_main_n) > 1) begin failures++; $display("FAIL rand_mutex c=%0d got=%b exp=at_most_one_low", c, a_main_n); end
      checks++; if (a_main_n !== exp_amn() || grant_valid !== (m_owner >= 0) ||
                    grant_idx !== 2'(m_owner < 0 ? 0 : m_owner) || busy_cnt !== 8'(m_cnt)) begin
        failures++; $display("FAIL rand_model c=%0d got=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d", c,
                             a_main_n, grant_valid, grant_idx, busy_cnt,
                             exp_amn(), (m_owner >= 0), (m_owner < 0 ? 0 : m_owner), m_cnt);
      end
    end
    checks++; if (max_wait > bound) begin failures++; $display("FAIL rand_starve got=%0d exp<=%0d", max_wait, bound); end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; lock = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotate();
    test_lock_hold();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
